// File: rtl/wb_arbiter.sv
// Write-back arbiter and destination-register scoreboard.
// Arbitrates the single register-file write port between the ALU and the
// load/store unit with a round-robin pointer. The winning write is registered
// toward the register file. One busy bit per register records issued
// instructions whose result has not been written yet.
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_rd_data_i,
    output logic                  alu_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_rd_data_i,
    output logic                  lsu_ready_o,
    input  logic                  issue_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_wren_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  err_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Despite its name, rst_ni is an active-high synchronous reset.
    logic                  srst;
    assign srst = rst_ni;

    // Round-robin pointer: 1 means the LSU wins the next contested cycle.
    logic                  prio_lsu_reg;
    logic                  prio_lsu_next;

    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;

    logic                  rd_wren_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  err_reg;
    logic                  err_next;

    logic                  contested;
    logic                  alu_grant;
    logic                  lsu_grant;
    logic                  any_grant;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    logic                  issue_hit;
    logic                  issue_waw;
    logic                  orphan_write;

    // Grant selection; nothing is granted while reset is held so a pending
    // request is dropped and must be re-presented.
    always_comb begin
        contested = alu_valid_i && lsu_valid_i;
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!srst) begin
            if (contested) begin
                lsu_grant = prio_lsu_reg;
                alu_grant = !prio_lsu_reg;
            end else begin
                alu_grant = alu_valid_i;
                lsu_grant = lsu_valid_i;
            end
        end
        any_grant     = alu_grant || lsu_grant;
        win_addr      = lsu_grant ? lsu_rd_addr_i : alu_rd_addr_i;
        win_data      = lsu_grant ? lsu_rd_data_i : alu_rd_data_i;
        // The pointer moves only when both requesters competed.
        prio_lsu_next = (contested && !srst) ? !prio_lsu_reg : prio_lsu_reg;
    end

    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;

    // Per-register busy update: an issue setting the bit overrides the write
    // clearing it on the same edge. Register 0 never becomes busy.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = issue_i && (issue_rd_addr_i == ADDR_WIDTH'(gi));
            assign clr_bit = rd_wren_reg && (rd_addr_reg == ADDR_WIDTH'(gi));
            assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    // Protocol checks. A register whose write is retiring on this very edge
    // is already in the file, so re-issuing it now is not a WAW violation.
    always_comb begin
        issue_hit    = issue_i && (issue_rd_addr_i != '0);
        issue_waw    = issue_hit && busy_reg[issue_rd_addr_i]
                       && !(rd_wren_reg && (rd_addr_reg == issue_rd_addr_i));
        orphan_write = any_grant && (win_addr != '0) && !busy_reg[win_addr];
        err_next     = err_reg || issue_waw || orphan_write;
    end

    // State update: pointer, scoreboard, registered write port and error flag.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            prio_lsu_reg <= 1'b1;
            busy_reg     <= '0;
            rd_wren_reg  <= 1'b0;
            rd_addr_reg  <= '0;
            rd_data_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            prio_lsu_reg <= prio_lsu_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            rd_wren_reg  <= any_grant && (win_addr != '0);
            if (any_grant) begin
                rd_addr_reg <= win_addr;
                rd_data_reg <= win_data;
            end
        end
    end

    assign rs1_busy_o = busy_reg[rs1_addr_i];
    assign rs2_busy_o = busy_reg[rs2_addr_i];
    assign rd_wren_o  = rd_wren_reg;
    assign rd_addr_o  = rd_addr_reg;
    assign rd_data_o  = rd_data_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_addr_i;
    logic [31:0] alu_rd_data_i;
    logic        alu_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_addr_i;
    logic [31:0] lsu_rd_data_i;
    logic        lsu_ready_o;
    logic        issue_i;
    logic [4:0]  issue_rd_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        err_o;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .alu_valid_i     (alu_valid_i),
        .alu_rd_addr_i   (alu_rd_addr_i),
        .alu_rd_data_i   (alu_rd_data_i),
        .alu_ready_o     (alu_ready_o),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_rd_addr_i   (lsu_rd_addr_i),
        .lsu_rd_data_i   (lsu_rd_data_i),
        .lsu_ready_o     (lsu_ready_o),
        .issue_i         (issue_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_busy_o      (rs1_busy_o),
        .rs2_busy_o      (rs2_busy_o),
        .rd_wren_o       (rd_wren_o),
        .rd_addr_o       (rd_addr_o),
        .rd_data_o       (rd_data_o),
        .err_o           (err_o)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni = 1'b1;
        alu_valid_i = 1'b0; alu_rd_addr_i = '0; alu_rd_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_rd_data_i = '0;
        issue_i = 1'b0; issue_rd_addr_i = '0;
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
        tick();
        tick();
        rst_ni = 1'b0;
        settle();
        check_vec("reset_wren", 32'(rd_wren_o), 32'd0);
        check_vec("reset_addr", 32'(rd_addr_o), 32'd0);
        check_vec("reset_data", rd_data_o, 32'd0);
        check_vec("reset_err", 32'(err_o), 32'd0);
        check_vec("reset_busy5", 32'(rs1_busy_o), 32'd0);

        // ALU write to x5 without a prior issue.
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_rd_data_i = 32'h0000_00AA;
        settle();
        check_vec("t1_alu_ready", 32'(alu_ready_o), 32'd1);
        check_vec("t1_lsu_ready", 32'(lsu_ready_o), 32'd0);
        tick();
        alu_valid_i = 1'b0;
        check_vec("t1_wren", 32'(rd_wren_o), 32'd1);
        check_vec("t1_addr", 32'(rd_addr_o), 32'd5);
        check_vec("t1_data", rd_data_o, 32'h0000_00AA);
        check_vec("t1_err", 32'(err_o), 32'd1);
        tick();
        check_vec("t1_wren_drop", 32'(rd_wren_o), 32'd0);

        // Clear the sticky error.
        rst_ni = 1'b1;
        tick();
        rst_ni = 1'b0;
        settle();
        check_vec("t1_err_cleared", 32'(err_o), 32'd0);

        // Issue x7, LSU returns 0x1234 three cycles later.
        rs1_addr_i = 5'd7;
        issue_i = 1'b1; issue_rd_addr_i = 5'd7;
        settle();
        check_vec("t2_busy_pre", 32'(rs1_busy_o), 32'd0);
        tick();
        issue_i = 1'b0;
        check_vec("t2_busy_c1", 32'(rs1_busy_o), 32'd1);
        tick();
        check_vec("t2_busy_c2", 32'(rs1_busy_o), 32'd1);
        tick();
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd7; lsu_rd_data_i = 32'h0000_1234;
        settle();
        check_vec("t2_lsu_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        lsu_valid_i = 1'b0;
        check_vec("t2_wren", 32'(rd_wren_o), 32'd1);
        check_vec("t2_addr", 32'(rd_addr_o), 32'd7);
        check_vec("t2_data", rd_data_o, 32'h0000_1234);
        check_vec("t2_busy_wr", 32'(rs1_busy_o), 32'd1);
        tick();
        check_vec("t2_busy_clr", 32'(rs1_busy_o), 32'd0);
        check_vec("t2_err", 32'(err_o), 32'd0);

        // Issue x1..x4, then contested write-backs.
        for (int i = 1; i <= 4; i++) begin
            issue_i = 1'b1; issue_rd_addr_i = 5'(i);
            tick();
        end
        issue_i = 1'b0;
        rs1_addr_i = 5'd1; rs2_addr_i = 5'd4;
        settle();
        check_vec("t3_busy1", 32'(rs1_busy_o), 32'd1);
        check_vec("t3_busy4", 32'(rs2_busy_o), 32'd1);
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd1; alu_rd_data_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd2; lsu_rd_data_i = 32'h22;
        settle();
        check_vec("t3_g1_lsu", 32'(lsu_ready_o), 32'd1);
        check_vec("t3_g1_alu", 32'(alu_ready_o), 32'd0);
        tick();
        lsu_rd_addr_i = 5'd4; lsu_rd_data_i = 32'h44;
        check_vec("t3_w1_addr", 32'(rd_addr_o), 32'd2);
        check_vec("t3_w1_wren", 32'(rd_wren_o), 32'd1);
        check_vec("t3_g2_alu", 32'(alu_ready_o), 32'd1);
        check_vec("t3_g2_lsu", 32'(lsu_ready_o), 32'd0);
        tick();
        alu_rd_addr_i = 5'd3; alu_rd_data_i = 32'h33;
        check_vec("t3_w2_addr", 32'(rd_addr_o), 32'd1);
        check_vec("t3_w2_data", rd_data_o, 32'h11);
        check_vec("t3_w2_wren", 32'(rd_wren_o), 32'd1);
        check_vec("t3_g3_lsu", 32'(lsu_ready_o), 32'd1);
        check_vec("t3_g3_alu", 32'(alu_ready_o), 32'd0);
        tick();
        lsu_valid_i = 1'b0;
        check_vec("t3_w3_addr", 32'(rd_addr_o), 32'd4);
        check_vec("t3_w3_wren", 32'(rd_wren_o), 32'd1);
        settle();
        check_vec("t3_g4_alu", 32'(alu_ready_o), 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check_vec("t3_w4_addr", 32'(rd_addr_o), 32'd3);
        check_vec("t3_w4_data", rd_data_o, 32'h33);
        check_vec("t3_w4_wren", 32'(rd_wren_o), 32'd1);
        tick();
        check_vec("t3_busy1_clr", 32'(rs1_busy_o), 32'd0);
        check_vec("t3_busy4_clr", 32'(rs2_busy_o), 32'd0);
        check_vec("t3_err", 32'(err_o), 32'd0);

        // Write to x0 is granted but never reaches the file.
        rs1_addr_i = 5'd0;
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd0; lsu_rd_data_i = 32'hFFFF_FFFF;
        settle();
        check_vec("t4_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        lsu_valid_i = 1'b0;
        check_vec("t4_wren", 32'(rd_wren_o), 32'd0);
        check_vec("t4_data", rd_data_o, 32'hFFFF_FFFF);
        check_vec("t4_busy0", 32'(rs1_busy_o), 32'd0);
        check_vec("t4_err", 32'(err_o), 32'd0);

        // Re-issue of x9 on the edge its write retires, then a WAW issue.
        rs1_addr_i = 5'd9;
        issue_i = 1'b1; issue_rd_addr_i = 5'd9;
        tick();
        issue_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd9; alu_rd_data_i = 32'h99;
        tick();
        alu_valid_i = 1'b0;
        check_vec("t5_wren9", 32'(rd_wren_o), 32'd1);
        issue_i = 1'b1; issue_rd_addr_i = 5'd9;
        tick();
        issue_i = 1'b0;
        check_vec("t5_busy9_kept", 32'(rs1_busy_o), 32'd1);
        check_vec("t5_err_clean", 32'(err_o), 32'd0);
        issue_i = 1'b1; issue_rd_addr_i = 5'd9;
        tick();
        issue_i = 1'b0;
        check_vec("t5_err_waw", 32'(err_o), 32'd1);
        tick();
        tick();
        check_vec("t5_err_sticky", 32'(err_o), 32'd1);

        // Reset with both requesters valid and x3 busy.
        issue_i = 1'b1; issue_rd_addr_i = 5'd3;
        tick();
        issue_i = 1'b0;
        rs2_addr_i = 5'd3;
        settle();
        check_vec("t6_busy3_pre", 32'(rs2_busy_o), 32'd1);
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd10; alu_rd_data_i = 32'hA0;
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd11; lsu_rd_data_i = 32'hB0;
        rst_ni = 1'b1;
        settle();
        check_vec("t6_alu_ready_rst", 32'(alu_ready_o), 32'd0);
        check_vec("t6_lsu_ready_rst", 32'(lsu_ready_o), 32'd0);
        tick();
        check_vec("t6_lsu_ready_rst2", 32'(lsu_ready_o), 32'd0);
        rst_ni = 1'b0;
        settle();
        check_vec("t6_wren", 32'(rd_wren_o), 32'd0);
        check_vec("t6_busy3", 32'(rs2_busy_o), 32'd0);
        check_vec("t6_busy9", 32'(rs1_busy_o), 32'd0);
        check_vec("t6_err", 32'(err_o), 32'd0);
        check_vec("t6_lsu_first", 32'(lsu_ready_o), 32'd1);
        check_vec("t6_alu_first", 32'(alu_ready_o), 32'd0);
        tick();
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        check_vec("t6_addr", 32'(rd_addr_o), 32'd11);
        check_vec("t6_data", rd_data_o, 32'hB0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
